restoring_divider_ctrl: RTL and testbench

//   Sequential unsigned N-bit divider built around one shared n_bit_adder_subtructor.

---
 rtl/restoring_divider_ctrl_pkg.sv | 19 +
 rtl/restoring_divider_ctrl_addsub.sv | 22 ++
 rtl/restoring_divider_ctrl.sv | 164 ++++++++++++++++
 tb/tb_restoring_divider_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/restoring_divider_ctrl_pkg.sv
// Shared types for the restoring divider controller.
// State codes and counter sizing helper.
package restoring_divider_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Iteration counter width; at least one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/restoring_divider_ctrl_addsub.sv
// Combinational N-bit adder/subtractor.
// sub=1 computes a + ~b + 1; c_out=1 then means a >= b.
module n_bit_adder_subtructor #(
  parameter int N = 4
) (
  input  logic         sub,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         c_out,
  output logic [N-1:0] s
);

  logic [N-1:0] b_x;

  assign b_x = b ^ {N{sub}};

  // Single carry-propagating sum with sub as carry-in.
  assign {c_out, s} = {1'b0, a}
                    + {1'b0, b_x}
                    + {{N{1'b0}}, sub};

endmodule

// File: rtl/restoring_divider_ctrl.sv
// Sequential unsigned restoring divider.
// One quotient bit per clock through a shared add/sub.
module restoring_divider_ctrl
  import restoring_divider_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int CW = cnt_w(N);
  localparam int W  = N + 1;

  state_e state_q, state_d;

  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  d_q, d_d;
  logic [N-1:0]  quot_q, quot_d;
  logic [N-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dbz_q, dbz_d;

  logic          run;
  logic          accept;
  logic [W-1:0]  rs;
  logic [W-1:0]  as_a;
  logic [W-1:0]  as_b;
  logic [W-1:0]  as_s;
  logic          as_c;
  logic          as_sub;
  logic          unused_s_msb;

  assign run    = (state_q == S_RUN);
  assign accept = start & ~run;

  // Partial remainder is held in N bits: it is
  // always below the divisor between steps.
  assign rs     = {r_q, q_q[N-1]};
  assign as_sub = 1'b1;
  assign as_a   = run ? rs : '0;
  assign as_b   = run ? {1'b0, d_q} : '0;

  n_bit_adder_subtructor #(
    .N (W)
  ) u_addsub (
    .sub   (as_sub),
    .a     (as_a),
    .b     (as_b),
    .c_out (as_c),
    .s     (as_s)
  );

  // Rs - D < D when it does not borrow, so the
  // difference MSB is always zero.
  assign unused_s_msb = as_s[N];

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = (divisor == '0) ? S_DONE
                                    : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (1'b1)
      (state_q == S_RUN):  busy = 1'b1;
      (state_q == S_DONE): done = 1'b1;
      default: ;
    endcase
  end

  // Datapath and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      q_q    <= q_d;
      d_q    <= d_d;
      cnt_q  <= cnt_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end

  // Load on accept, one restoring step per RUN cycle.
  always_comb begin
    r_d    = r_q;
    q_d    = q_q;
    d_d    = d_q;
    cnt_d  = cnt_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (accept) begin
      if (divisor != '0) begin
        r_d   = '0;
        q_d   = dividend;
        d_d   = divisor;
        cnt_d = CW'(N - 1);
        dbz_d = 1'b0;
      end else begin
        quot_d = '1;
        rem_d  = dividend;
        dbz_d  = 1'b1;
      end
    end else if (run) begin
      r_d = as_c ? as_s[N-1:0] : rs[N-1:0];
      q_d = {q_q[N-2:0], as_c};
      if (cnt_q == '0) begin
        quot_d = q_d;
        rem_d  = r_d;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_ctrl.sv
// Scoreboard bench for restoring_divider_ctrl.
// Driver pushes expectations; monitor checks on done.
module tb_restoring_divider_ctrl;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] dividend = '0;
  logic [N-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  restoring_divider_ctrl #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
    int           cyc;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pop and compare whenever done is seen.
  always @(negedge clk) begin
    if (busy && done) begin
      n_vec++;
      n_err++;
      $display("FAIL busy_and_done at cycle %0d", cyc);
    end
    if (rst_n && done) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL spurious_done at cycle %0d", cyc);
      end else begin
        me = sb.pop_front();
        if (quotient !== me.q || remainder !== me.r ||
            div_by_zero !== me.z || cyc != me.cyc) begin
          n_err++;
          $display({"FAIL result: got q=%0d r=%0d z=%0b cyc=%0d,",
                    " want q=%0d r=%0d z=%0b cyc=%0d"},
                   quotient, remainder, div_by_zero, cyc,
                   me.q, me.r, me.z, me.cyc);
        end
      end
    end
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  // Called at a negedge; start is sampled at the next posedge.
  task automatic push_exp(input logic [N-1:0] q,
                          input logic [N-1:0] r,
                          input logic z,
                          input int lat);
    exp_t e;
    e.q = q;
    e.r = r;
    e.z = z;
    e.cyc = cyc + lat;
    sb.push_back(e);
  endtask

  task automatic issue(input logic [N-1:0] a,
                       input logic [N-1:0] b,
                       input logic [N-1:0] q,
                       input logic [N-1:0] r,
                       input logic z);
    dividend = a;
    divisor = b;
    start = 1'b1;
    push_exp(q, r, z, z ? 1 : N + 1);
    @(negedge clk);
    start = 1'b0;
    dividend = N'($urandom);
    divisor = N'($urandom);
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40 && (sb.size() != 0 || busy); i++)
      @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0 || busy) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout: %0d results pending", sb.size());
      sb.delete();
    end
  endtask

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         z;
  } vec_t;

  vec_t tbl[9] = '{
    '{4'd13, 4'd3,  4'd4,  4'd1,  1'b0},
    '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0},
    '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0},
    '{4'd0,  4'd5,  4'd0,  4'd0,  1'b0},
    '{4'd7,  4'd0,  4'd15, 4'd7,  1'b1},
    '{4'd14, 4'd4,  4'd3,  4'd2,  1'b0},
    '{4'd12, 4'd7,  4'd1,  4'd5,  1'b0},
    '{4'd1,  4'd2,  4'd0,  4'd1,  1'b0},
    '{4'd0,  4'd0,  4'd15, 4'd0,  1'b1}
  };

  initial begin
    int c0;
    logic [N-1:0] ra, rb;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_quot", 32'(quotient), 0);
    chk("rst_rem", 32'(remainder), 0);
    chk("rst_dbz", 32'(div_by_zero), 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (tbl[i]) begin
      issue(tbl[i].a, tbl[i].b, tbl[i].q,
            tbl[i].r, tbl[i].z);
      wait_idle();
    end

    // Start pulsed mid-RUN must be ignored.
    issue(4'd9, 4'd2, 4'd4, 4'd1, 1'b0);
    @(negedge clk);
    dividend = 4'd1;
    divisor = 4'd1;
    start = 1'b1;
    chk("midrun_busy", 32'(busy), 1);
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Reset mid-RUN aborts without a done.
    dividend = 4'd13;
    divisor = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_quot", 32'(quotient), 0);
    chk("abort_rem", 32'(remainder), 0);
    chk("abort_dbz", 32'(div_by_zero), 0);
    repeat (8) @(negedge clk);
    issue(4'd10, 4'd3, 4'd3, 4'd1, 1'b0);
    wait_idle();

    // Back-to-back: start held through DONE.
    c0 = cyc;
    dividend = 4'd13;
    divisor = 4'd3;
    start = 1'b1;
    push_exp(4'd4, 4'd1, 1'b0, N + 1);
    push_exp(4'd1, 4'd2, 1'b0, 2 * (N + 1));
    @(negedge clk);
    dividend = 4'd6;
    divisor = 4'd4;
    while (cyc < c0 + N + 2) @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    wait_idle();

    // Back-to-back into a divide-by-zero.
    c0 = cyc;
    dividend = 4'd11;
    divisor = 4'd2;
    start = 1'b1;
    push_exp(4'd5, 4'd1, 1'b0, N + 1);
    push_exp(4'd15, 4'd9, 1'b1, N + 2);
    @(negedge clk);
    dividend = 4'd9;
    divisor = 4'd0;
    while (cyc < c0 + N + 2) @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Extra pairs against a / and % model.
    for (int k = 0; k < 30; k++) begin
      ra = N'($urandom);
      rb = N'($urandom);
      if (rb == '0)
        issue(ra, rb, '1, ra, 1'b1);
      else
        issue(ra, rb, ra / rb, ra % rb, 1'b0);
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
